// File: rtl/wisc_cpu_pkg.sv
// Shared opcode, branch-condition and flag definitions for the WISC single-cycle core,
// plus the saturation and branch-decision helpers used by the execute stage.
package wisc_cpu_pkg;

    localparam logic [3:0] OpAdd    = 4'h0;
    localparam logic [3:0] OpPaddsb = 4'h1;
    localparam logic [3:0] OpSub    = 4'h2;
    localparam logic [3:0] OpNand   = 4'h3;
    localparam logic [3:0] OpXor    = 4'h4;
    localparam logic [3:0] OpSll    = 4'h5;
    localparam logic [3:0] OpSrl    = 4'h6;
    localparam logic [3:0] OpSra    = 4'h7;
    localparam logic [3:0] OpLw     = 4'h8;
    localparam logic [3:0] OpSw     = 4'h9;
    localparam logic [3:0] OpLhb    = 4'ha;
    localparam logic [3:0] OpLlb    = 4'hb;
    localparam logic [3:0] OpB      = 4'hc;
    localparam logic [3:0] OpJal    = 4'hd;
    localparam logic [3:0] OpJr     = 4'he;
    localparam logic [3:0] OpHlt    = 4'hf;

    localparam logic [2:0] CccNe     = 3'b000;
    localparam logic [2:0] CccEq     = 3'b001;
    localparam logic [2:0] CccGt     = 3'b010;
    localparam logic [2:0] CccLt     = 3'b011;
    localparam logic [2:0] CccGte    = 3'b100;
    localparam logic [2:0] CccLte    = 3'b101;
    localparam logic [2:0] CccOvfl   = 3'b110;
    localparam logic [2:0] CccAlways = 3'b111;

    localparam int unsigned FlagZ = 0;
    localparam int unsigned FlagV = 1;
    localparam int unsigned FlagN = 2;

    typedef enum logic [0:0] {StRun, StHalt} run_state_e;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
    } sat16_t;

    // Operands arrive sign-extended to 17 bits; bits 16 and 15 disagree only on overflow.
    function automatic sat16_t sat16(input logic [16:0] s);
        sat16_t r;
        r.ovf = s[16] ^ s[15];
        r.res = r.ovf ? (s[16] ? 16'h8000 : 16'h7fff) : s[15:0];
        return r;
    endfunction

    function automatic logic [7:0] sat8(input logic [8:0] s);
        logic [7:0] r;
        if (s[8] ^ s[7]) r = s[8] ? 8'h80 : 8'h7f;
        else             r = s[7:0];
        return r;
    endfunction

    function automatic logic branch_taken(input logic [2:0] ccc, input logic [2:0] flags);
        logic z, v, n, t;
        z = flags[FlagZ];
        v = flags[FlagV];
        n = flags[FlagN];
        case (ccc)
            CccNe:     t = !z;
            CccEq:     t = z;
            CccGt:     t = !z && !n;
            CccLt:     t = n;
            CccGte:    t = z || !n;
            CccLte:    t = n || z;
            CccOvfl:   t = v;
            CccAlways: t = 1'b1;
            default:   t = 1'b1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/wisc_cpu_if.sv
// Status bus of the WISC core: halt indication and current program counter.
interface wisc_cpu_if;
    logic        hlt;
    logic [15:0] pc;

    modport master (output hlt, output pc);
    modport slave  (input hlt, input pc);
endinterface

// File: rtl/wisc_cpu_regfile.sv
// 16x16 register file, two async read ports and one sync write port; R0 reads as zero.
// Reset is synchronous and active-high.
module wisc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    input  logic [3:0]  wa,
    input  logic [15:0] wd,
    input  logic        we,
    output logic [15:0] rd1,
    output logic [15:0] rd2
);
    logic [15:0] regs [16];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (we && (wa != 4'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 4'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 4'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/wisc_cpu.sv
// Single-cycle 16-bit WISC core: every instruction fetches, executes and retires in one clock.
// Note: rst_n is synchronous and active-HIGH despite its name.
module wisc_cpu
    import wisc_cpu_pkg::*;
#(
    parameter string       IMEM_FILE = "instr.hex",
    parameter int unsigned MEM_AW    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    wisc_cpu_if.master bus
);
    localparam int unsigned Depth = 2 ** MEM_AW;

    logic [15:0] imem [Depth];
    logic [15:0] dmem [Depth];

    logic [15:0] pc_q, pc_d, pc_inc;
    logic [2:0]  flags_q, flags_d;
    run_state_e  state_q, state_d;
    logic        running;

    logic [15:0] instr;
    logic [3:0]  op, f_rd, f_rs, f_rt;
    logic [7:0]  imm8;
    logic [3:0]  ra1, ra2, wa;
    logic [15:0] rs_val, rt_val, mem_addr, wb_data;
    logic        rf_we, mem_we, set_z;
    sat16_t      sum;

    assign instr = imem[pc_q[MEM_AW-1:0]];
    assign op    = instr[15:12];
    assign f_rd  = instr[11:8];
    assign f_rs  = instr[7:4];
    assign f_rt  = instr[3:0];
    assign imm8  = instr[7:0];

    // LHB merges into rd's old low byte and SW stores rd's value, so both read rd instead.
    assign ra1      = (op == OpLhb) ? f_rd : f_rs;
    assign ra2      = (op == OpSw)  ? f_rd : f_rt;
    assign wa       = (op == OpJal) ? 4'd15 : f_rd;
    assign pc_inc   = pc_q + 16'd1;
    assign mem_addr = rs_val + {{12{f_rt[3]}}, f_rt};
    assign running  = (state_q == StRun);

    wisc_regfile u_rf (
        .clk (clk),
        .rst (rst_n),
        .ra1 (ra1),
        .ra2 (ra2),
        .wa  (wa),
        .wd  (wb_data),
        .we  (rf_we && running),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    always_comb begin
        wb_data = '0;
        rf_we   = 1'b0;
        mem_we  = 1'b0;
        set_z   = 1'b0;
        flags_d = flags_q;
        pc_d    = pc_inc;
        sum     = '0;
        case (op)
            OpAdd, OpSub: begin
                sum = sat16((op == OpAdd) ? ({rs_val[15], rs_val} + {rt_val[15], rt_val})
                                          : ({rs_val[15], rs_val} - {rt_val[15], rt_val}));
                wb_data        = sum.res;
                rf_we          = 1'b1;
                set_z          = 1'b1;
                flags_d[FlagV] = sum.ovf;
                flags_d[FlagN] = sum.res[15];
            end
            OpPaddsb: begin
                wb_data = {sat8({rs_val[15], rs_val[15:8]} + {rt_val[15], rt_val[15:8]}),
                           sat8({rs_val[7], rs_val[7:0]} + {rt_val[7], rt_val[7:0]})};
                rf_we   = 1'b1;
            end
            OpNand: begin wb_data = ~(rs_val & rt_val);         rf_we = 1'b1; set_z = 1'b1; end
            OpXor:  begin wb_data = rs_val ^ rt_val;            rf_we = 1'b1; set_z = 1'b1; end
            OpSll:  begin wb_data = rs_val << f_rt;             rf_we = 1'b1; set_z = 1'b1; end
            OpSrl:  begin wb_data = rs_val >> f_rt;             rf_we = 1'b1; set_z = 1'b1; end
            OpSra:  begin wb_data = $signed(rs_val) >>> f_rt;   rf_we = 1'b1; set_z = 1'b1; end
            OpLw:   begin wb_data = dmem[mem_addr[MEM_AW-1:0]]; rf_we = 1'b1; end
            OpSw:   mem_we = 1'b1;
            OpLhb:  begin wb_data = {imm8, rs_val[7:0]};        rf_we = 1'b1; end
            OpLlb:  begin wb_data = {{8{imm8[7]}}, imm8};       rf_we = 1'b1; end
            OpB: begin
                if (branch_taken(instr[11:9], flags_q)) pc_d = pc_inc + {{7{instr[8]}}, instr[8:0]};
            end
            OpJal: begin
                wb_data = pc_inc;
                rf_we   = 1'b1;
                pc_d    = pc_inc + {{4{instr[11]}}, instr[11:0]};
            end
            OpJr:   pc_d = rs_val;
            OpHlt:  pc_d = pc_q;
            default: ;
        endcase
        if (set_z) flags_d[FlagZ] = (wb_data == '0);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q    <= '0;
            flags_q <= '0;
        end else if (running) begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && running && mem_we) dmem[mem_addr[MEM_AW-1:0]] <= rt_val;
    end

    always_ff @(posedge clk) begin
        if (rst_n) state_q <= StRun;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (op == OpHlt) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        bus.hlt = (state_q == StHalt);
    end

    assign bus.pc = pc_q;

endmodule

// File: tb/tb_wisc_cpu.sv
// Bench for wisc_cpu: a directed program pinned by literal expectations, then random programs
// checked every cycle against an instruction-level model of the ISA.
module tb_wisc_cpu;
    import wisc_cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    wisc_cpu_if bus ();

    wisc_cpu #(
        .IMEM_FILE (""),
        .MEM_AW    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [65536];
    logic [15:0] mm  [65536];
    logic [15:0] mr  [16];
    logic [15:0] m_pc, m_sw_addr;
    logic        m_hlt, m_z, m_v, m_n;
    bit          m_sw_seen = 1'b0;
    bit          chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_hlt = 1'b0;
        m_z   = 1'b0;
        m_v   = 1'b0;
        m_n   = 1'b0;
        for (int i = 0; i < 16; i++) mr[i] = '0;
    endtask

    // One architectural instruction, computed with integer arithmetic.
    task automatic model_step();
        logic [15:0] ins, a, b, res, nxt, addr;
        int op, d, s, t, x, hi, lo;
        bit wr, zonly, take;
        if (m_hlt) return;
        ins   = rom[m_pc];
        op    = int'(ins[15:12]);
        d     = int'(ins[11:8]);
        s     = int'(ins[7:4]);
        t     = int'(ins[3:0]);
        a     = mr[s];
        b     = mr[t];
        nxt   = m_pc + 16'd1;
        addr  = a + {{12{ins[3]}}, ins[3:0]};
        res   = '0;
        wr    = 1'b0;
        zonly = 1'b0;
        take  = 1'b0;
        case (op)
            0, 2: begin
                if (op == 0) x = int'($signed(a)) + int'($signed(b));
                else         x = int'($signed(a)) - int'($signed(b));
                m_v = (x > 32767) || (x < -32768);
                if (x > 32767) x = 32767;
                else if (x < -32768) x = -32768;
                res = x[15:0];
                wr  = 1'b1;
                m_z = (res == 16'd0);
                m_n = res[15];
            end
            1: begin
                hi = int'($signed(a[15:8])) + int'($signed(b[15:8]));
                lo = int'($signed(a[7:0])) + int'($signed(b[7:0]));
                if (hi > 127) hi = 127; else if (hi < -128) hi = -128;
                if (lo > 127) lo = 127; else if (lo < -128) lo = -128;
                res = {hi[7:0], lo[7:0]};
                wr  = 1'b1;
            end
            3: begin res = ~(a & b); wr = 1'b1; zonly = 1'b1; end
            4: begin res = a ^ b;    wr = 1'b1; zonly = 1'b1; end
            5: begin res = a << t;   wr = 1'b1; zonly = 1'b1; end
            6: begin res = a >> t;   wr = 1'b1; zonly = 1'b1; end
            7: begin x = int'($signed(a)) >>> t; res = x[15:0]; wr = 1'b1; zonly = 1'b1; end
            8: begin res = mm[addr]; wr = 1'b1; end
            9: begin mm[addr] = mr[d]; m_sw_addr = addr; m_sw_seen = 1'b1; end
            10: begin res = {ins[7:0], mr[d][7:0]}; wr = 1'b1; end
            11: begin res = {{8{ins[7]}}, ins[7:0]}; wr = 1'b1; end
            12: begin
                case (int'(ins[11:9]))
                    0: take = !m_z;
                    1: take = m_z;
                    2: take = !m_z && !m_n;
                    3: take = m_n;
                    4: take = m_z || !m_n;
                    5: take = m_n || m_z;
                    6: take = m_v;
                    default: take = 1'b1;
                endcase
                if (take) nxt = nxt + {{7{ins[8]}}, ins[8:0]};
            end
            13: begin res = nxt; d = 15; wr = 1'b1; nxt = nxt + {{4{ins[11]}}, ins[11:0]}; end
            14: nxt = a;
            default: begin m_hlt = 1'b1; nxt = m_pc; end
        endcase
        if (zonly) m_z = (res == 16'd0);
        if (wr && d != 0) mr[d] = res;
        m_pc = nxt;
    endtask

    always @(posedge clk) begin
        if (rst_n) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            check("pc", bus.pc, m_pc);
            check("hlt", {15'd0, bus.hlt}, {15'd0, m_hlt});
            check("flags", {13'd0, dut.flags_q[FlagN], dut.flags_q[FlagV], dut.flags_q[FlagZ]},
                  {13'd0, m_n, m_v, m_z});
            for (int i = 1; i < 16; i++) check($sformatf("r%0d", i), dut.u_rf.regs[i], mr[i]);
            if (m_sw_seen) check("dmem", dut.dmem[m_sw_addr], mm[m_sw_addr]);
        end
    end

    task automatic load_rom();
        for (int i = 0; i < 65536; i++) dut.imem[i] = rom[i];
    endtask

    // Memory ops use base R0 so every reachable data address is seeded by the preamble.
    task automatic gen_random_rom();
        logic [15:0] w;
        for (int k = 0; k < 16; k++) rom[k] = 16'h9000 | 16'(k);
        for (int i = 16; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hf && $urandom_range(0, 3) != 0) w[15:12] = 4'($urandom_range(0, 14));
            if (w[15:12] == 4'h8 || w[15:12] == 4'h9) w[7:4] = 4'h0;
            rom[i] = w;
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b1;
        for (int i = 0; i < 65536; i++) rom[i] = 16'hf000;
        rom[16'h00] = 16'hb17f;  // LLB R1,0x7F
        rom[16'h01] = 16'ha17f;  // LHB R1,0x7F
        rom[16'h02] = 16'h0211;  // ADD R2,R1,R1
        rom[16'h03] = 16'hb305;  // LLB R3,0x05
        rom[16'h04] = 16'h9302;  // SW  R3,R0,2
        rom[16'h05] = 16'h8402;  // LW  R4,R0,2
        rom[16'h06] = 16'h2533;  // SUB R5,R3,R3
        rom[16'h07] = 16'hc202;  // B EQ,+2
        rom[16'h08] = 16'hb6ee;  // skipped
        rom[16'h09] = 16'hb6ee;  // skipped
        rom[16'h0a] = 16'hc005;  // B NE,+5 (not taken)
        rom[16'h0b] = 16'hce04;  // B always -> 0x10
        rom[16'h10] = 16'hd003;  // JAL +3
        rom[16'h11] = 16'hce0e;  // B always -> 0x20
        rom[16'h14] = 16'he0f0;  // JR R15
        rom[16'h20] = 16'hf000;  // HLT
        load_rom();

        repeat (2) @(negedge clk);
        check("rst_pc", bus.pc, 16'h0000);
        check("rst_hlt", {15'd0, bus.hlt}, 16'h0000);
        chk_en = 1'b1;
        rst_n  = 1'b0;

        @(negedge clk); check("pc_step1", bus.pc, 16'h0001);
        @(negedge clk); check("pc_step2", bus.pc, 16'h0002);
        @(negedge clk);
        check("add_sat_r2", dut.u_rf.regs[2], 16'h7fff);
        check("add_flags_nvz", {13'd0, dut.flags_q[FlagN], dut.flags_q[FlagV], dut.flags_q[FlagZ]},
              16'h0002);

        k = 0;
        while (!bus.hlt && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("hlt_latency", 16'(k), 16'd11);
        check("hlt_pc", bus.pc, 16'h0020);
        check("lw_r4", dut.u_rf.regs[4], 16'h0005);
        check("sub_r5", dut.u_rf.regs[5], 16'h0000);
        check("skip_r6", dut.u_rf.regs[6], 16'h0000);
        check("jal_r15", dut.u_rf.regs[15], 16'h0011);
        check("model_r2", mr[2], 16'h7fff);
        check("model_r15", mr[15], 16'h0011);

        repeat (10) @(negedge clk);
        check("frozen_pc", bus.pc, 16'h0020);
        check("frozen_hlt", {15'd0, bus.hlt}, 16'h0001);
        check("frozen_r2", dut.u_rf.regs[2], 16'h7fff);
        check("frozen_flags", {13'd0, dut.flags_q[FlagN], dut.flags_q[FlagV], dut.flags_q[FlagZ]},
              16'h0001);

        for (int r = 0; r < 6; r++) begin
            rst_n = 1'b1;
            gen_random_rom();
            load_rom();
            @(negedge clk);
            rst_n = 1'b0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (r == 2 && c == 150) rst_n = 1'b1;
                if (r == 2 && c == 151) begin
                    check("midrst_pc", bus.pc, 16'h0000);
                    check("midrst_hlt", {15'd0, bus.hlt}, 16'h0000);
                    rst_n = 1'b0;
                end
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
